// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
//   op_e      - 3-bit operation encoding presented on the op input
//   state_e   - control FSM states (IDLE / BUSY / DONE)
//   FLAG_*    - bit positions inside the 4-bit flags output {dz, ovf, carry, zero}
//   pack_flags- assembles a flags word from the individual flag bits
package alu_mc_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_DIV  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_DZ    = 3;

    function automatic logic [3:0] pack_flags(input logic dz, input logic ovf,
                                              input logic carry, input logic zero);
        logic [3:0] f;
        f             = '0;
        f[FLAG_DZ]    = dz;
        f[FLAG_OVF]   = ovf;
        f[FLAG_CARRY] = carry;
        f[FLAG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result handshake bundle of the multi-cycle ALU.
//   in_valid/in_ready   operand-side handshake, a/b/op carried with it
//   out_valid/out_ready result-side handshake, z/flags carried with it
//   modport master: operand source + result sink (drives in_*, out_ready)
//   modport slave : the ALU itself
interface alu_mc_if #(parameter int WIDTH = 8);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           op;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   z;
    logic [3:0]           flags;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, z, flags
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, z, flags
    );

endinterface

// File: rtl/alu_mc_div.sv
// alu_mc_div: restoring divider, one quotient bit per clock.
//   clk, rst   clock / synchronous active-high reset (control only)
//   start      load dividend/divisor and begin WIDTH iterations
//   dividend   numerator sampled on start
//   divisor    denominator sampled on start (must be non-zero)
//   done       high during the final iteration
//   quo, rem   result produced by the iteration running this cycle;
//              valid as the final answer when done is high
// Only built when ALU_MC_DIV_EN is defined.
module alu_mc_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo_p0;
    logic [WIDTH-1:0] rem_p0;
    logic [WIDTH-1:0] dvs_p0;

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] rem_n;

    // Shift the next dividend bit into the remainder and trial-subtract; a
    // borrow out of bit WIDTH means the divisor did not fit, so restore.
    always_comb begin
        partial = {rem_p0, quo_p0[WIDTH-1]};
        diff    = partial - {1'b0, dvs_p0};
        if (!diff[WIDTH]) begin
            rem_n = diff[WIDTH-1:0];
            quo_n = {quo_p0[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = partial[WIDTH-1:0];
            quo_n = {quo_p0[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
                busy <= 1'b0;
            end
        end
    end

    // ---- iteration registers (p0) ----
    always_ff @(posedge clk) begin
        if (start) begin
            quo_p0 <= dividend;
            rem_p0 <= '0;
            dvs_p0 <= divisor;
        end else if (busy) begin
            quo_p0 <= quo_n;
            rem_p0 <= rem_n;
        end
    end

    assign done = busy && (cnt == CNT_W'(WIDTH - 1));
    assign quo  = quo_n;
    assign rem  = rem_n;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU with valid/ready handshakes.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        alu_mc_if.slave: in_valid/in_ready/a/b/op in,
//              out_valid/out_ready/z/flags out ({dz, ovf, carry, zero})
// Ops: ADD SUB AND OR XOR PASS_A finish in one cycle; MUL (shift-add) and
// DIV (restoring) take WIDTH+1 cycles. One operation in flight at a time.
// Build option: define ALU_MC_DIV_EN to instantiate the divider; without it
// op 6 completes in one cycle with z=0 and dz=1.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    alu_mc_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int W2    = 2 * WIDTH;

    state_e             state;
    state_e             state_n;
    logic               rdy;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic               accept;
    logic               is_multi;
    op_e                op_in;

    logic [W2-1:0]      z_q;
    logic [3:0]         flags_q;
    logic [W2-1:0]      z1;
    logic [3:0]         f1;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic               dz1;
    logic               ovf1;
    logic               carry1;

    logic [WIDTH-1:0]   a_p0;
    logic [W2-1:0]      mul_p0;
    logic [WIDTH:0]     mul_add;
    logic [W2-1:0]      mul_n;
    logic               div_done;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] d);
        return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign op_in  = op_e'(bus.op);
    assign accept = bus.in_valid && rdy;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        is_multi = (op_in == OP_MUL);
`ifdef ALU_MC_DIV_EN
        if (op_in == OP_DIV && bus.b != '0) begin
            is_multi = 1'b1;
        end
`endif
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = is_multi ? BUSY : DONE;
            BUSY:    if (last) state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Single-cycle result, computed straight from the operands being accepted.
    always_comb begin
        sum    = {1'b0, bus.a} + {1'b0, bus.b};
        dif    = {1'b0, bus.a} - {1'b0, bus.b};
        z1     = '0;
        dz1    = 1'b0;
        ovf1   = 1'b0;
        carry1 = 1'b0;
        case (op_in)
            OP_ADD: begin
                z1     = {{(WIDTH-1){1'b0}}, sum};
                carry1 = sum[WIDTH];
                ovf1   = add_ovf(bus.a, bus.b, sum[WIDTH-1:0]);
            end
            OP_SUB: begin
                z1     = {{WIDTH{1'b0}}, dif[WIDTH-1:0]};
                carry1 = dif[WIDTH];
                ovf1   = sub_ovf(bus.a, bus.b, dif[WIDTH-1:0]);
            end
            OP_AND:  z1 = {{WIDTH{1'b0}}, bus.a & bus.b};
            OP_OR:   z1 = {{WIDTH{1'b0}}, bus.a | bus.b};
            OP_XOR:  z1 = {{WIDTH{1'b0}}, bus.a ^ bus.b};
            OP_PASS: z1 = {{WIDTH{1'b0}}, bus.a};
            OP_DIV: begin
                // Reached here only for b==0 when the divider is present.
                dz1 = 1'b1;
`ifdef ALU_MC_DIV_EN
                z1  = {bus.a, {WIDTH{1'b1}}};
`endif
            end
            default: z1 = '0;
        endcase
        f1 = pack_flags(dz1, ovf1, carry1, z1 == '0);
    end

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole product right.
    assign mul_add = {1'b0, mul_p0[W2-1:WIDTH]} + (mul_p0[0] ? {1'b0, a_p0} : '0);
    assign mul_n   = {mul_add, mul_p0[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             div_start;

    assign div_start = accept && (op_in == OP_DIV) && (bus.b != '0);

    alu_mc_div #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (bus.a),
        .divisor  (bus.b),
        .done     (div_done),
        .quo      (div_quo),
        .rem      (div_rem)
    );
`else
    assign div_done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rdy     <= 1'b0;
            cnt     <= '0;
            z_q     <= '0;
            flags_q <= '0;
        end else begin
            state <= state_n;
            rdy   <= (state_n == IDLE);
            if (state == IDLE && accept) begin
                cnt <= '0;
                if (!is_multi) begin
                    z_q     <= z1;
                    flags_q <= f1;
                end
            end else if (state == BUSY) begin
                cnt <= cnt + CNT_W'(1);
                if (div_done) begin
`ifdef ALU_MC_DIV_EN
                    z_q     <= {div_rem, div_quo};
                    flags_q <= pack_flags(1'b0, 1'b0, 1'b0, {div_rem, div_quo} == '0);
`endif
                end else if (last) begin
                    z_q     <= mul_n;
                    flags_q <= pack_flags(1'b0, 1'b0, |mul_n[W2-1:WIDTH], mul_n == '0);
                end
            end
        end
    end

    // ---- operand / partial-product registers (p0) ----
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            a_p0   <= bus.a;
            mul_p0 <= {{WIDTH{1'b0}}, bus.b};
        end else if (state == BUSY) begin
            mul_p0 <= mul_n;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = (state == DONE);
    assign bus.z         = z_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [15:0] last_z;
    logic [3:0]  last_f;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: flags = {dz, ovf, carry, zero}; lat = edges from accept to out_valid.
    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] z, output logic [3:0] f, output int lat);
        int sa, sb, r;
        logic dz, ovf, carry;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = 0; ovf = 0; carry = 0; lat = 1; z = 0;
        case (op)
            3'd0: begin
                r = int'(a) + int'(b); z = 16'(r); carry = (r > 255);
                ovf = (sa + sb > 127) || (sa + sb < -128);
            end
            3'd1: begin
                r = int'(a) - int'(b); z = 16'(r & 255); carry = (a < b);
                ovf = (sa - sb > 127) || (sa - sb < -128);
            end
            3'd2: begin
                z = 16'(int'(a) * int'(b)); carry = (z > 16'd255); lat = W + 1;
            end
            3'd3: z = {8'd0, a & b};
            3'd4: z = {8'd0, a | b};
            3'd5: z = {8'd0, a ^ b};
            3'd6: begin
`ifdef ALU_MC_DIV_EN
                if (b == 0) begin
                    z = {a, 8'hFF}; dz = 1;
                end else begin
                    z = {8'(a % b), 8'(a / b)}; lat = W + 1;
                end
`else
                z = 0; dz = 1;
`endif
            end
            default: z = {8'd0, a};
        endcase
        f = {dz, ovf, carry, (z == 0)};
    endfunction

    // Called at a negedge with the ALU idle; returns at a negedge with it idle again.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold, input bit junk);
        logic [15:0] ez;
        logic [3:0]  ef;
        int          elat;
        int          lat;
        model(op, a, b, ez, ef, elat);
        chk("in_ready_idle", 64'(bus.in_ready), 64'(1));
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.op        = op;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = junk;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.op       = 3'($urandom);
        chk("in_ready_drop", 64'(bus.in_ready), 64'(0));
        lat = 1;
        while (!bus.out_valid && lat < 4 * W) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(elat));
        chk("z", 64'(bus.z), 64'(ez));
        chk("flags", 64'(bus.flags), 64'(ef));
        last_z = bus.z;
        last_f = bus.flags;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.out_valid), 64'(1));
            chk("hold_z", 64'(bus.z), 64'(ez));
            chk("hold_flags", 64'(bus.flags), 64'(ef));
            chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("valid_drop", 64'(bus.out_valid), 64'(0));
    endtask

    initial begin
        bit seen;
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;

        // Reset held three cycles.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_z", 64'(bus.z), 64'(0));
        chk("rst_flags", 64'(bus.flags), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'(0));

        // Directed cases with literal expectations.
        run_op(3'd0, 8'd200, 8'd100, 0, 0);
        chk("add_lit_z", 64'(last_z), 64'h012C);
        chk("add_lit_f", 64'(last_f), 64'b0010);
        run_op(3'd1, 8'd5, 8'd7, 0, 0);
        chk("sub_lit_z", 64'(last_z), 64'h00FE);
        chk("sub_lit_f", 64'(last_f), 64'b0010);
        run_op(3'd0, 8'h7F, 8'h01, 0, 0);
        chk("add_ovf_f", 64'(last_f), 64'b0100);
        run_op(3'd1, 8'd9, 8'd9, 0, 0);
        chk("sub_zero_z", 64'(last_z), 64'h0000);
        chk("sub_zero_f", 64'(last_f), 64'b0001);
        run_op(3'd2, 8'd255, 8'd255, 0, 1);
        chk("mul_lit_z", 64'(last_z), 64'hFE01);
        chk("mul_lit_f", 64'(last_f), 64'b0010);
        run_op(3'd6, 8'd100, 8'd7, 0, 1);
`ifdef ALU_MC_DIV_EN
        chk("div_lit_z", 64'(last_z), 64'h020E);
        chk("div_lit_f", 64'(last_f), 64'b0000);
`else
        chk("div_off_z", 64'(last_z), 64'h0000);
        chk("div_off_f", 64'(last_f), 64'b1001);
`endif
        run_op(3'd6, 8'd42, 8'd0, 0, 0);
`ifdef ALU_MC_DIV_EN
        chk("div0_lit_z", 64'(last_z), 64'h2AFF);
        chk("div0_lit_f", 64'(last_f), 64'b1000);
`else
        chk("div0_off_z", 64'(last_z), 64'h0000);
        chk("div0_off_f", 64'(last_f), 64'b1001);
`endif
        // Sink stalls five cycles in DONE.
        run_op(3'd5, 8'hA5, 8'h3C, 5, 1);
        run_op(3'd7, 8'h00, 8'hFF, 2, 0);

        // Reset in the middle of a multiply aborts it.
        bus.in_valid = 1'b1;
        bus.a        = 8'd13;
        bus.b        = 8'd11;
        bus.op       = 3'd2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            if (bus.out_valid) seen = 1;
            @(negedge clk);
        end
        chk("abort_no_valid", 64'(seen), 64'(0));
        chk("abort_in_ready", 64'(bus.in_ready), 64'(1));

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (op == 3'd6 && $urandom_range(0, 3) == 0) b = 8'd0;
            if (op == 3'd1 && $urandom_range(0, 3) == 0) b = a;
            run_op(op, a, b, int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
